// File: rtl/fixed_div_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fixed_div_seq_if
// Brief    : Operand/result handshake bundle for the sequential Fixed divider.
// Revision : 1.0
// ============================================================================
interface fixed_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, div_by_zero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/fixed_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : fixed_div_seq
// Brief    : Signed fixed-point divider, restoring, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
module fixed_div_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic           clk,
  input  logic           reset,
  fixed_div_seq_if.slave bus
);

  localparam int c_steps = WIDTH + FRAC;
  localparam int c_cnt_w = $clog2(c_steps);
  localparam logic [c_cnt_w-1:0] c_last      = c_cnt_w'(c_steps - 1);
  localparam logic [WIDTH-1:0]   c_fixed_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   c_fixed_min = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
  localparam logic [c_steps-1:0] c_pos_lim   = c_steps'(c_fixed_max);
  localparam logic [c_steps-1:0] c_neg_lim   = c_pos_lim + c_steps'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_in_ready;
  logic                 w_out_valid;

  logic                 r_sa;
  logic                 r_sb;
  logic [WIDTH-1:0]     r_abs_b;
  logic [c_steps-1:0]   r_dividend;
  logic [WIDTH:0]       r_rem;
  logic [c_steps-1:0]   r_quot;
  logic [c_cnt_w-1:0]   r_count;
  logic [WIDTH-1:0]     r_q;
  logic                 r_dbz;
  logic                 r_ovf;

  logic                 w_accept;
  logic                 w_b_zero;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH+1:0]     w_t;
  logic                 w_ge;
  logic [WIDTH:0]       w_rem_next;
  logic [c_steps-1:0]   w_quot_next;
  logic                 w_last;
  logic [WIDTH-1:0]     w_res_q;
  logic                 w_res_ovf;

  assign w_accept    = bus.in_valid && (r_state == IDLE);
  assign w_b_zero    = (bus.b == '0);
  assign w_abs_a     = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_abs_b     = bus.b[WIDTH-1] ? -bus.b : bus.b;

  // Trial subtraction: the difference fits in WIDTH+1 bits whenever it is taken.
  assign w_t         = {r_rem, r_dividend[c_steps-1]};
  assign w_ge        = (w_t >= {2'b00, r_abs_b});
  assign w_rem_next  = w_ge ? (w_t[WIDTH:0] - {1'b0, r_abs_b}) : w_t[WIDTH:0];
  assign w_quot_next = (r_quot << 1) | c_steps'(w_ge);
  assign w_last      = (r_state == BUSY) && (r_count == c_last);

  always_comb begin
    w_res_q   = w_quot_next[WIDTH-1:0];
    w_res_ovf = 1'b0;
    if (r_sa ^ r_sb) begin
      if (w_quot_next > c_neg_lim) begin
        w_res_q   = c_fixed_min;
        w_res_ovf = 1'b1;
      end else begin
        w_res_q = -w_quot_next[WIDTH-1:0];
      end
    end else if (w_quot_next > c_pos_lim) begin
      w_res_q   = c_fixed_max;
      w_res_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = w_b_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (r_count == c_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_abs_b    <= '0;
      r_dividend <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_count    <= '0;
      r_q        <= '0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_accept) begin
      r_sa       <= bus.a[WIDTH-1];
      r_sb       <= bus.b[WIDTH-1];
      r_abs_b    <= w_abs_b;
      r_dividend <= {w_abs_a, {FRAC{1'b0}}};
      r_rem      <= '0;
      r_quot     <= '0;
      r_count    <= '0;
      if (w_b_zero) begin
        r_q   <= bus.a[WIDTH-1] ? c_fixed_min : c_fixed_max;
        r_dbz <= 1'b1;
        r_ovf <= 1'b0;
      end
    end else if (r_state == BUSY) begin
      r_dividend <= r_dividend << 1;
      r_rem      <= w_rem_next;
      r_quot     <= w_quot_next;
      r_count    <= r_count + c_cnt_w'(1);
      if (w_last) begin
        r_q   <= w_res_q;
        r_dbz <= 1'b0;
        r_ovf <= w_res_ovf;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.q           = r_q;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fixed_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_div_seq
// Brief    : Directed vectors with a queue-based scoreboard for fixed_div_seq.
// Revision : 1.0
// ============================================================================
module tb_fixed_div_seq;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fixed_div_seq_if #(.WIDTH(32)) bus ();

  fixed_div_seq #(
    .WIDTH(32),
    .FRAC (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t r_exp;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Results are checked on the cycle the consumer takes them.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got q=%h with no pending request", bus.q);
      end else begin
        r_exp = sb.pop_front();
        chk("q", bus.q, r_exp.q);
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(r_exp.dbz));
        chk("overflow", 32'(bus.overflow), 32'(r_exp.ovf));
      end
    end
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                     input logic edbz, input logic eovf, input int lat, input int hold);
    int n;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    sb.push_back({eq, edbz, eovf});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 32'h0;
    bus.b        = 32'h0;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    for (int i = 0; i < hold; i++) begin
      chk("hold_q", bus.q, eq);
      chk("hold_flags", {30'd0, bus.div_by_zero, bus.overflow}, {30'd0, edbz, eovf});
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_after_take", 32'(bus.out_valid), 32'd0);
    chk("in_ready_after_take", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_q", bus.q, 32'h0);
    chk("reset_flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    run(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 48, 0);
    run(32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, 48, 0);
    run(32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0,  0);
    run(32'hFFFF_0000, 32'h0000_0000, 32'h8000_0001, 1'b1, 1'b0, 0,  0);
    run(32'h7FFF_0000, 32'h0000_0100, 32'h7FFF_FFFF, 1'b0, 1'b1, 48, 0);
    run(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 48, 0);
    run(32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 48, 0);
    run(32'h0005_0000, 32'hFFFE_0000, 32'hFFFD_8000, 1'b0, 1'b0, 48, 0);
    run(32'h8000_0000, 32'h0000_8000, 32'h8000_0001, 1'b0, 1'b1, 48, 0);
    run(32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0, 48, 0);
    run(32'hFFFE_0000, 32'hFFFF_0000, 32'h0002_0000, 1'b0, 1'b0, 48, 0);
    run(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 48, 10);

    // Abort a division part-way through; no result may emerge from it.
    bus.a        = 32'h0003_0000;
    bus.b        = 32'h0002_0000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_q", bus.q, 32'h0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    bus.a        = 32'h0001_0000;
    bus.b        = 32'h0000_0000;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ignores_in_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    @(posedge clk); #1;
    chk("post_abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_abort_out_valid", 32'(bus.out_valid), 32'd0);
    run(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 48, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog timeout");
  end

endmodule
`default_nettype wire

// File: doc/fixed_div_seq.md
# fixed_div_seq

Sequential signed fixed-point divider for the `Fixed` type, the inverse of the combinational fixed-point multiplier. It computes q = a / b with the same sign-magnitude convention as the multiply path, one quotient bit per clock, behind valid/ready handshakes. It serves shading and intersection stages that need reciprocals or ratios without a wide combinational divider.

## Interface
- WIDTH, default `FIXED_WIDTH` (32): total bits of a `Fixed` value, two's complement.
- FRAC, default `FIXED_FRAC_WIDTH` (16): fractional bits.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a and b are valid.
- in_ready  out  1  divider can accept operands; equals (state == IDLE).
- a  in  WIDTH  dividend, `Fixed`.
- b  in  WIDTH  divisor, `Fixed`.
- out_valid  out  1  q and the flags are valid.
- out_ready  in  1  consumer takes the result.
- q  out  WIDTH  quotient, `Fixed`.
- div_by_zero  out  1  b was 0 for this result.
- overflow  out  1  the quotient saturated.

## Operation
- State machine IDLE -> BUSY -> DONE -> IDLE.
- **Accept** (in_valid && in_ready, IDLE only):
  - Latch sa = a[WIDTH-1] and sb = b[WIDTH-1].
  - Latch |a| and |b| as unsigned WIDTH bits. |0x80..0| = 2^(WIDTH-1).
  - Dividend D = |a| << FRAC, WIDTH+FRAC bits. Remainder R = 0, WIDTH+1 bits. Quotient Q = 0, WIDTH+FRAC bits. Iteration counter = 0.
  - If b == 0, go directly to DONE with:
    - q = 0x7FFF_FFFF when sa = 0, or 0x8000_0001 when sa = 1 (±FIXED_MAX).
    - div_by_zero = 1, overflow = 0.
  - Otherwise go to BUSY.
- **BUSY**, restoring division, one step per cycle:
  - T = {R, D[msb]}, then D <<= 1.
  - If T >= |b|: R = T - |b| and shift 1 into Q. Else R = T and shift 0 into Q.
  - Runs exactly WIDTH+FRAC steps (48 at default widths), then goes to DONE.
- **Result formation**, on the transition into DONE:
  - Let M = Q, truncated toward zero. Negative result when sa ^ sb.
  - Positive result: if M > 2^(WIDTH-1)-1, q = 0x7FFF_FFFF and overflow = 1; else q = M.
  - Negative result: if M > 2^(WIDTH-1), q = 0x8000_0001 and overflow = 1; else q = -M in two's complement. M = 2^(WIDTH-1) gives 0x8000_0000 with no overflow.
- **DONE**:
  - out_valid = 1. q and the flags are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE and deassert out_valid.
- No overlap: in_ready = 0 in BUSY and DONE. Inputs are ignored outside IDLE.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1 once reset deasserts.
  - out_valid = 0, q = 0, div_by_zero = 0, overflow = 0.
  - All internal registers = 0.
- Reset is asynchronous and takes effect immediately in any state. An in-flight division is discarded and no out_valid is produced. in_valid is ignored while reset is high.
- Latency, counted from the accepting edge E0:
  - b ≠ 0: BUSY steps on edges E1..E48; out_valid is high after E48 (WIDTH+FRAC cycles).
  - b = 0: out_valid is high after E0 (1 cycle).
- Return to IDLE on the edge where out_ready is sampled high with out_valid. in_ready rises in the following cycle.
- Throughput: one result per WIDTH+FRAC+2 cycles at minimum, with out_ready held high.
- out_ready high while out_valid is low has no effect.
- in_valid held high through a result: the next accept happens in the first IDLE cycle.
- q and the flags change only on the transition into DONE or on reset.

## Test plan
- **Basic divide:** a=0x0003_0000, b=0x0002_0000 (3/2) -> after 48 cycles out_valid=1, q=0x0001_8000, both flags 0.
- **Negative truncation:** a=0xFFFF_0000, b=0x0003_0000 (-1/3) -> q=0xFFFF_AAAB (magnitude 0x5555 truncated, then negated), flags 0.
- **Divide by zero:** a=0x0001_0000, b=0 -> out_valid 1 cycle after accept, q=0x7FFF_FFFF, div_by_zero=1. With a=0xFFFF_0000, b=0 -> q=0x8000_0001.
- **Overflow and boundary:**
  - a=0x7FFF_0000, b=0x0000_0100 -> q=0x7FFF_FFFF, overflow=1.
  - a=0x8000_0000, b=0x0001_0000 -> q=0x8000_0000, overflow=0.
  - a=0x8000_0000, b=0xFFFF_0000 -> q=0x7FFF_FFFF, overflow=1.
- **Back-pressure:** hold out_ready=0 for 10 cycles after out_valid -> q and flags stable and in_ready=0 throughout. Raise out_ready -> out_valid drops next cycle and in_ready=1.
- **Reset mid-operation:** assert reset 20 cycles into BUSY -> out_valid=0, q=0 and in_ready=1 immediately. A new 3/2 request then completes normally with q=0x0001_8000.
